// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: synchronises rx, times bits with a wrapping counter, samples mid-bit.
// Latency: byte/flags registered one cycle after the stop-bit sample (9*BIT_CYCLES+MID after START).
// Backpressure: one-entry output via rx_valid/rx_ready; a byte completing while full is dropped with overrun.
module uart_rx_ctrl #(
  parameter int unsigned BIT_CYCLES = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [31:0] MID  = 32'((BIT_CYCLES - 1) / 2);
  localparam logic [31:0] LAST = 32'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        rx_s, tick, mid, handshake;

  assign rx_s = sync2_q;
  assign tick = (cnt_q == LAST);
  assign mid  = (cnt_q == MID);

  // Next-state, bit timing, sampling and output handshake.
  always_comb begin
    state_d     = state_q;
    sync1_d     = rx;
    sync2_d     = sync1_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    handshake   = rx_valid_q && rx_ready;

    if (handshake) begin
      rx_valid_d = 1'b0;
    end

    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s) state_d = START;
        end
        START: begin
          // A high line at mid-bit means a glitch, not a start bit.
          if (mid && rx_s) begin
            state_d = IDLE;
          end else if (tick) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
        DATA: begin
          if (mid) shift_d = {rx_s, shift_q[7:1]};
          if (tick) begin
            if (bit_idx_q == 3'd7) state_d = STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        STOP: begin
          // Leave at mid-stop so the next start edge can be caught early.
          if (mid) begin
            state_d = IDLE;
            if (!rx_s) begin
              frame_err_d = 1'b1;
            end else if (!rx_valid_q || handshake) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Counter restarts on entry to a frame and on every bit boundary.
    if (state_q == IDLE || state_d == IDLE || tick) cnt_d = '0;
    else                                            cnt_d = cnt_q + 32'd1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule
